// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bundle of the two requester channels, the response
// channel and the status outputs of alu_share_arbiter.
//   master: requester/consumer side (drives valids, operands, rsp_ready)
//   slave : arbiter side (drives readies, response fields, busy, op_count)
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    logic             busy;
    logic [15:0]      op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        input  busy, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        output busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one ALU through a round-robin
// arbiter. Each op walks IDLE (accept) -> EXEC (compute) -> RESP (hold until
// the consumer takes it), so at most one op is in flight.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - alu_share_arbiter_if.slave: request/response channels and status
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           r_state;
    state_e           w_state_next;

    // 1 when requester 1 was granted last; reset value makes requester 0 win the first tie
    logic             r_last_grant;
    logic             w_grant_id;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_id;

    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic             r_rsp_id;
    logic [15:0]      r_op_count;

    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic             w_slt;
    logic             w_rsp_fire;

    assign w_slt = $signed(r_a) < $signed(r_b);

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            3'b000:  w_result = r_a & r_b;
            3'b001:  w_result = r_a | r_b;
            3'b010:  w_result = r_a + r_b;
            3'b011:  w_result = r_a ^ r_b;
            3'b110:  w_result = r_a - r_b;
            3'b111:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        // Alternate on a tie, otherwise take whichever requester is valid
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = bus.req1_valid;
        end
        case (r_state)
            StIdle: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StExec;
                end
            end
            StExec: w_state_next = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_rsp_fire = (r_state == StResp) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 3'b000;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_op_count   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a          <= w_grant_id ? bus.req1_a  : bus.req0_a;
                r_b          <= w_grant_id ? bus.req1_b  : bus.req0_b;
                r_op         <= w_grant_id ? bus.req1_op : bus.req0_op;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == StExec) begin
                r_rsp_data <= w_result;
                r_rsp_zero <= (w_result == '0);
                r_rsp_err  <= w_err;
                r_rsp_id   <= r_id;
            end
            if (w_rsp_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign bus.req0_ready = w_accept && !reset && !w_grant_id;
    assign bus.req1_ready = w_accept && !reset && w_grant_id;
    assign bus.rsp_valid  = (r_state == StResp);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != StIdle);
    assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter
// against a behavioural model (arithmetic ALU reference plus a tie-winner flag
// and a response counter).
module tb_alu_share_arbiter;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic        prefer;     // requester that wins the next tie
    logic [15:0] exp_count;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU written from the operation table with plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic err);
        longint sa;
        longint sb;
        sa  = a[31] ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb  = b[31] ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        err = 1'b0;
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            3'd3:    return a ^ b;
            3'd6:    return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            3'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                err = 1'b1;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic drop_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // One full transaction from IDLE, with `stall` cycles of backpressure in RESP
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int stall);
        logic        win;
        logic [31:0] ed;
        logic        ee;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        #1;
        if (!v0 && !v1) begin
            chk("idle_rdy0", bus.req0_ready, 0);
            chk("idle_rdy1", bus.req1_ready, 0);
            tick();
            chk("idle_busy", bus.busy, 0);
            return;
        end
        win = (v0 && v1) ? prefer : v1;
        ed  = win ? ref_alu(op1, a1, b1, ee) : ref_alu(op0, a0, b0, ee);
        chk("grant_rdy0", bus.req0_ready, (win == 1'b0));
        chk("grant_rdy1", bus.req1_ready, (win == 1'b1));
        tick();
        // Winner drops and scribbles its inputs; the loser keeps waiting
        if (win) begin
            bus.req1_valid = 1'b0;
            bus.req1_a     = $urandom;
            bus.req1_op    = 3'($urandom);
        end else begin
            bus.req0_valid = 1'b0;
            bus.req0_a     = $urandom;
            bus.req0_op    = 3'($urandom);
        end
        #1;
        chk("exec_busy", bus.busy, 1);
        chk("exec_rspv", bus.rsp_valid, 0);
        chk("exec_rdy", {bus.req0_ready, bus.req1_ready}, 0);
        tick();
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, win);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_zero", bus.rsp_zero, (ed == 32'd0));
        chk("rsp_err", bus.rsp_err, ee);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, ed);
            chk("bp_rdy", {bus.req0_ready, bus.req1_ready}, 0);
            chk("bp_count", bus.op_count, exp_count);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        exp_count     = exp_count + 16'd1;
        prefer        = ~win;
        chk("done_valid", bus.rsp_valid, 0);
        chk("done_busy", bus.busy, 0);
        chk("done_count", bus.op_count, exp_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        tick();
        drop_reqs();
        reset     = 1'b0;
        prefer    = 1'b0;
        exp_count = 16'd0;
        #1;
        chk("rst_rspv", bus.rsp_valid, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_zero", bus.rsp_zero, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.op_count, 0);
    endtask

    initial begin
        logic [31:0] edge_vals [5];
        edge_vals[0] = 32'h0;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h1;

        reset         = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req0_op   = 3'd0;
        bus.req1_op   = 3'd0;
        bus.req0_a    = '0;
        bus.req0_b    = '0;
        bus.req1_a    = '0;
        bus.req1_b    = '0;
        drop_reqs();
        do_reset();

        // Contention from reset: requester 0 first, then the waiting requester 1
        run_txn(1, 1, 3'b001, 32'h0, 32'h0, 3'b010, 32'hFFFF_FFFF, 32'h1, 0);
        run_txn(0, 1, 3'b001, 32'h0, 32'h0, 3'b010, 32'hFFFF_FFFF, 32'h1, 0);

        // Single AND with backpressure
        run_txn(1, 0, 3'b000, 32'h0003_FFFF, 32'hFFFF_FFFF, 3'b000, 32'h0, 32'h0, 5);

        // SLT and SUB corners, illegal ops, idle cycle
        run_txn(0, 1, 3'b000, 32'h0, 32'h0, 3'b111, 32'hFFFF_FFFF, 32'h1, 0);
        run_txn(1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 3'b000, 32'h0, 32'h0, 1);
        run_txn(1, 0, 3'b100, 32'h1234_5678, 32'h9, 3'b000, 32'h0, 32'h0, 0);
        run_txn(0, 1, 3'b000, 32'h0, 32'h0, 3'b101, 32'hFFFF, 32'h1, 2);
        run_txn(0, 0, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 0);

        // Reset while in EXEC discards the op
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b100;
        bus.req0_a     = 32'h5;
        bus.req0_b     = 32'h6;
        tick();
        drop_reqs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rexec_rspv", bus.rsp_valid, 0);
        chk("rexec_busy", bus.busy, 0);
        chk("rexec_count", bus.op_count, 0);
        tick();
        chk("rexec_rspv2", bus.rsp_valid, 0);
        chk("rexec_count2", bus.op_count, 0);
        // Pointer favours requester 0 again after reset
        run_txn(1, 1, 3'b011, 32'hF0F0_F0F0, 32'hFFFF_0000, 3'b000, 32'h1, 32'h1, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra0;
            logic [31:0] rb0;
            logic [31:0] ra1;
            logic [31:0] rb1;
            ra0 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            rb1 = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            run_txn(1'($urandom), 1'($urandom), 3'($urandom), ra0, rb0,
                    3'($urandom), ra1, rb1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
